// File: rtl/fifo_uart_drain_if.sv
// fifo_uart_drain_if: FIFO-side and serial-side signals of the UART drain
interface fifo_uart_drain_if;
   logic       en;
   logic       fifo_empty;
   logic [7:0] fifo_d_out;
   logic       fifo_read;
   logic       tx;
   logic       busy;
   logic       byte_done;
   logic [7:0] tx_count;
   modport master (output en, fifo_empty, fifo_d_out, input fifo_read, tx, busy, byte_done, tx_count);
   modport slave (input en, fifo_empty, fifo_d_out, output fifo_read, tx, busy, byte_done, tx_count);
endinterface

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from a synchronous FIFO and sends each as an 8N1 serial frame
module fifo_uart_drain #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic clk,
   input logic rst,
   fifo_uart_drain_if.slave bus
);
   localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [W-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_n;
   logic [7:0] shift, shift_n, count;
   logic tx_r, read_r, done_r, last;
   assign last = cnt == LAST;
   assign bus.tx = tx_r;
   assign bus.fifo_read = read_r;
   assign bus.byte_done = done_r;
   assign bus.tx_count = count;
   assign bus.busy = state != IDLE;
   // next-state, shift register and bit index; the baud counter restarts on every state change
   always_comb begin
      state_n = state;
      shift_n = shift;
      bit_n = bit_idx;
      case (state)
         IDLE: if (bus.en && !bus.fifo_empty) state_n = POP;
         POP: state_n = LOAD;
         LOAD: begin
            shift_n = bus.fifo_d_out;
            state_n = START;
         end
         START: if (last) begin
            state_n = DATA;
            bit_n = '0;
         end
         DATA: if (last) begin
            if (bit_idx == 3'd7) state_n = STOP;
            else begin
               shift_n = shift >> 1;
               bit_n = bit_idx + 3'd1;
            end
         end
         STOP: if (last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      cnt_n = (state_n != state || last || state inside {IDLE, POP, LOAD}) ? '0 : cnt + 1'b1;
   end
   // state and registered outputs, each computed from the upcoming state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         tx_r <= 1'b1;
         read_r <= 1'b0;
         done_r <= 1'b0;
         count <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         shift <= shift_n;
         tx_r <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
         read_r <= state_n == POP;
         done_r <= state_n == STOP && cnt_n == LAST;
         if (state == STOP && last) count <= count + 8'd1;
      end
   end
endmodule

// File: doc/fifo_uart_drain.md
FIFO_UART_DRAIN -- requirements
Module: fifo_uart_drain

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  drain enable; sampled only in IDLE.
REQ-005 fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-006 fifo_d_out  input  8  FIFO read data; valid on the cycle after a FIFO read strobe.
REQ-007 fifo_read  output  1  FIFO read strobe, registered.
REQ-008 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 byte_done  output  1  one-cycle pulse on the last cycle of a stop bit.
REQ-011 tx_count  output  8  frames completed since reset, wraps 255->0.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, POP, LOAD, START, DATA, STOP.
REQ-013 IDLE -> POP when en=1 and fifo_empty=0; otherwise IDLE holds, tx=1.
REQ-014 In POP, fifo_read SHALL be 1 for exactly one cycle; it SHALL be 0 in every other state.
REQ-015 POP -> LOAD unconditionally; in LOAD the 8-bit shift register SHALL capture fifo_d_out, then LOAD -> START.
REQ-016 START drives tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-017 DATA drives shift[0] for CLKS_PER_BIT cycles per bit, shifts right after each bit, and sends 8 bits LSB first; bit index is 3 bits, 0..7.
REQ-018 STOP drives tx=1 for CLKS_PER_BIT cycles; on its final cycle byte_done=1 and tx_count increments; next state is IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive.
REQ-020 Cycles from the IDLE decision to the first START cycle SHALL be 3 (POP, LOAD, then START); minimum inter-frame gap SHALL be 1 IDLE cycle plus POP and LOAD.
REQ-021 The baud counter SHALL be wide enough for CLKS_PER_BIT-1, count 0..CLKS_PER_BIT-1, and clear on every state change.
REQ-022 Deasserting en mid-frame SHALL NOT abort the frame; the block completes STOP and then remains in IDLE.
REQ-023 fifo_empty and fifo_d_out SHALL be ignored outside IDLE and LOAD respectively.
REQ-024 The block SHALL issue no fifo_read while fifo_empty=1 (underflow protection), and never more than one read per frame.
REQ-025 tx SHALL be driven from a register (glitch-free).

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, tx=1, fifo_read=0, busy=0, byte_done=0, tx_count=0, shift register=0, baud counter=0, bit index=0.
REQ-027 Reset asserted mid-frame SHALL immediately force tx=1 and discard the frame; the FIFO entry already popped is lost, and no byte_done is issued.
REQ-028 After rst is released, the first transition out of IDLE SHALL occur no earlier than the first rising edge following release.

Verification
REQ-029 CLKS_PER_BIT=4, FIFO holds 0xA5, en=1 -> one fifo_read pulse; tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; byte_done at cycle 40 of the frame; tx_count=1.
REQ-030 FIFO holds 0x00,0xFF, en=1 -> two frames, each 40 cycles, separated by a 3-cycle gap with tx=1; exactly two fifo_read pulses; tx_count=2.
REQ-031 fifo_empty=1, en=1 for 100 cycles -> fifo_read=0, tx=1, busy=0 throughout.
REQ-032 en dropped during DATA bit 3 of 0x3C -> frame completes with correct bits; no further fifo_read while en=0, even if FIFO is non-empty.
REQ-033 rst pulsed during DATA -> tx=1 and busy=0 in the same cycle; tx_count=0; after release with en=1 and FIFO non-empty -> a fresh frame starts via POP.
REQ-034 Send 256 frames -> tx_count wraps to 0 on the 256th byte_done.
